// File: rtl/cic_pkg.sv
// -----------------------------------------------------------------------------
// cic_pkg
// Shared definitions for the CIC interpolator and decimator blocks.
//   cic_state_e   : sequencing state of the interpolator (IDLE, RUN)
//   cic_acc_width : internal accumulator width for a CIC with N stages,
//                   rate change R and differential delay M
// -----------------------------------------------------------------------------
package cic_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } cic_state_e;

    // Worst-case bit growth through N comb/integrator pairs is
    // N*clog2(R*M) bits on top of the input width.
    function automatic int cic_acc_width(input int nbw_in, input int n,
                                         input int r, input int m);
        return nbw_in + n * $clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_integ_stage.sv
// -----------------------------------------------------------------------------
// cic_integ_stage
// One integrator of the CIC chain: acc <= acc + add when enabled.
// Arithmetic wraps modulo 2^NBW_ACC; the CIC structure relies on that wrap.
// Ports:
//   clk  : clock
//   clr  : synchronous clear, highest priority
//   en   : accumulate enable
//   add  : value added to the accumulator
//   acc  : accumulator value
// -----------------------------------------------------------------------------
module cic_integ_stage #(
    parameter int NBW_ACC = 12
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               en,
    input  logic [NBW_ACC-1:0] add,
    output logic [NBW_ACC-1:0] acc
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // in the chain sees the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + add;
        end
    end

endmodule

// File: rtl/cic_interp_block.sv
// -----------------------------------------------------------------------------
// cic_interp_block
// N-stage CIC interpolator by R. Low-rate samples arrive over valid/ready,
// pass N comb stages at input rate, are zero-stuffed by R, pass N integrator
// stages at output rate and leave as one sample per i_out_en strobe.
// Optional build macro: CIC_ROUND_EN -- round half-up and saturate when the
// output is narrower than the accumulator (plain MSB truncation otherwise).
// Ports:
//   clk         : clock
//   rst_sync_n  : synchronous active-low reset
//   i_data      : input sample, signed
//   i_valid     : input sample valid
//   o_ready     : block can accept a sample this cycle
//   i_out_en    : output-rate strobe, one output per asserted cycle
//   o_data      : output sample, signed
//   o_valid     : o_data valid for one cycle
//   o_underflow : sticky, a sample was needed but the buffer was empty
// -----------------------------------------------------------------------------
module cic_interp_block
    import cic_pkg::*;
#(
    parameter int NBW_IN  = 8,
    parameter int NBI_IN  = 1,
    parameter int NBW_OUT = 8,
    parameter int NBI_OUT = 1,
    parameter int R       = 4,
    parameter int N       = 2,
    parameter int M       = 1
) (
    input  logic               clk,
    input  logic               rst_sync_n,
    input  logic [NBW_IN-1:0]  i_data,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_out_en,
    output logic [NBW_OUT-1:0] o_data,
    output logic               o_valid,
    output logic               o_underflow
);

    localparam int NBW_ACC = cic_acc_width(NBW_IN, N, R, M);
    localparam int NBW_PH  = $clog2(R);

    // Configuration sanity checks. The integer-bit parameters only describe
    // the fixed-point format, but they must fit inside their words.
    if (R < 2 || (R & (R - 1)) != 0) begin : g_bad_r
        $error("cic_interp_block: R must be a power of two >= 2");
    end
    if (N < 1 || N > 6) begin : g_bad_n
        $error("cic_interp_block: N must be in 1..6");
    end
    if (M < 1 || M > 2) begin : g_bad_m
        $error("cic_interp_block: M must be 1 or 2");
    end
    if (NBI_IN > NBW_IN || NBI_OUT > NBW_OUT) begin : g_bad_fmt
        $error("cic_interp_block: integer bits exceed word width");
    end

    cic_state_e        state_q, state_d;
    logic [NBW_PH-1:0] phase_q;
    logic [NBW_IN-1:0] buf_q;
    logic              buf_full;

    logic consume;     // a low-rate sample slot is taken on this strobe
    logic run_en;      // integrators/output advance on this strobe
    logic take_buf;    // the slot is filled from the buffer
    logic starve;      // the slot is filled with zero: buffer was empty
    logic load;
    logic buf_full_d;

    logic [NBW_ACC-1:0] comb_in [N+1];
    logic [NBW_ACC-1:0] stuff_q;
    logic [NBW_ACC-1:0] integ   [N];
    logic [NBW_OUT-1:0] out_next;

    // ------------------------------------------------------------------
    // Sequencing
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path
    // through the case can leave a latch behind.
    always_comb begin
        state_d = state_q;
        consume = 1'b0;
        run_en  = 1'b0;
        if (i_out_en) begin
            case (state_q)
                IDLE: begin
                    // Start only once real data is present; the phase is 0.
                    if (buf_full) begin
                        consume = 1'b1;
                        run_en  = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    run_en  = 1'b1;
                    consume = (phase_q == '0);
                end
            endcase
        end
    end

    assign take_buf   = consume & buf_full;
    assign starve     = consume & ~buf_full;
    assign load       = i_valid & o_ready;
    // A load only happens while empty, so it never collides with take_buf;
    // load still wins so a fresh sample is never dropped.
    assign buf_full_d = load | (buf_full & ~take_buf);

    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            buf_q       <= '0;
            buf_full    <= 1'b0;
            o_ready     <= 1'b0;
            stuff_q     <= '0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            state_q <= state_d;
            // R is a power of two, so the natural wrap gives R-1 -> 0.
            if (run_en) begin
                phase_q <= phase_q + NBW_PH'(1);
            end
            if (load) begin
                buf_q <= i_data;
            end
            buf_full <= buf_full_d;
            o_ready  <= ~buf_full_d;
            // Zero-stuffing: only the consuming strobe carries comb output.
            if (i_out_en) begin
                stuff_q <= consume ? comb_in[N] : '0;
            end
            o_valid <= run_en;
            if (run_en) begin
                o_data <= out_next;
            end
            if (starve) begin
                o_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Comb chain at input rate; delays advance only on consumption
    // ------------------------------------------------------------------
    assign comb_in[0] = take_buf ? {{(NBW_ACC-NBW_IN){buf_q[NBW_IN-1]}}, buf_q}
                                 : '0;

    for (genvar k = 0; k < N; k++) begin : g_comb
        logic [NBW_ACC-1:0] dly [M];

        // NOTE: these small delay arrays are reset on purpose: stale history
        // would otherwise leak into the first outputs after a reset.
        always_ff @(posedge clk) begin
            if (!rst_sync_n) begin
                for (int j = 0; j < M; j++) begin
                    dly[j] <= '0;
                end
            end else if (consume) begin
                dly[0] <= comb_in[k];
                for (int j = 1; j < M; j++) begin
                    dly[j] <= dly[j-1];
                end
            end
        end

        assign comb_in[k+1] = comb_in[k] - dly[M-1];
    end

    // ------------------------------------------------------------------
    // Integrator chain at output rate
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N; k++) begin : g_integ
        if (k == 0) begin : g_first
            cic_integ_stage #(.NBW_ACC(NBW_ACC)) u_integ (
                .clk (clk),
                .clr (~rst_sync_n),
                .en  (run_en),
                .add (stuff_q),
                .acc (integ[0])
            );
        end else begin : g_next
            cic_integ_stage #(.NBW_ACC(NBW_ACC)) u_integ (
                .clk (clk),
                .clr (~rst_sync_n),
                .en  (run_en),
                .add (integ[k-1]),
                .acc (integ[k])
            );
        end
    end

    // ------------------------------------------------------------------
    // Output width adaptation
    // ------------------------------------------------------------------
    if (NBW_OUT >= NBW_ACC) begin : g_out_ext
        assign out_next = NBW_OUT'($signed(integ[N-1]));
    end else begin : g_out_trunc
        localparam int SH = NBW_ACC - NBW_OUT;
`ifdef CIC_ROUND_EN
        localparam logic [NBW_ACC:0] HALF = {{NBW_ACC{1'b0}}, 1'b1} << (SH - 1);
        logic [NBW_ACC:0] rounded;
        logic [NBW_OUT:0] top;

        // One guard bit absorbs the rounding carry; if the guard and the
        // output sign disagree the result left the signed range.
        assign rounded  = {integ[N-1][NBW_ACC-1], integ[N-1]} + HALF;
        assign top      = (NBW_OUT+1)'(rounded >> SH);
        assign out_next = (top[NBW_OUT] != top[NBW_OUT-1])
                        ? {top[NBW_OUT], {(NBW_OUT-1){~top[NBW_OUT]}}}
                        : top[NBW_OUT-1:0];
`else
        assign out_next = NBW_OUT'(integ[N-1] >> SH);
`endif
    end

endmodule

// File: tb/tb_cic_interp_block.sv
// -----------------------------------------------------------------------------
// tb_cic_interp_block
// Directed bench for cic_interp_block with R=4, N=2, M=1. One instance runs
// at full precision (NBW_OUT=12), a second at NBW_OUT=8 for truncation.
// Expected values are hand-derived: the unit impulse response at output rate
// is 0,0,0,1,2,3,4,3,2,1,0,... and the DC gain is 4.
// -----------------------------------------------------------------------------
module tb_cic_interp_block;

    logic        clk = 1'b0;
    logic        rst_sync_n;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_out_en;

    logic        o_ready, o_valid, o_underflow;
    logic [11:0] o_data;
    logic        o_ready8, o_valid8, o_underflow8;
    logic [7:0]  o_data8;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]         feed [$];
    logic signed [31:0] got  [$];
    logic signed [31:0] got8 [$];
    logic               uf_q [$];

    int exp_imp  [12] = '{0, 0, 0, 1, 2, 3, 4, 3, 2, 1, 0, 0};
    int exp_step [8]  = '{0, 0, 0, 16, 32, 48, 64, 64};
    int exp_uf   [12] = '{0, 0, 0, 8, 16, 24, 32, 24, 16, 8, 0, 0};

`ifdef CIC_ROUND_EN
    localparam int EXP8_127 = 32;
`else
    localparam int EXP8_127 = 31;
`endif

    always #5 clk = ~clk;

    cic_interp_block #(
        .NBW_IN(8), .NBI_IN(1), .NBW_OUT(12), .NBI_OUT(1), .R(4), .N(2), .M(1)
    ) dut (
        .clk        (clk),
        .rst_sync_n (rst_sync_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_out_en   (i_out_en),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .o_underflow(o_underflow)
    );

    cic_interp_block #(
        .NBW_IN(8), .NBI_IN(1), .NBW_OUT(8), .NBI_OUT(1), .R(4), .N(2), .M(1)
    ) dut8 (
        .clk        (clk),
        .rst_sync_n (rst_sync_n),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready8),
        .i_out_en   (i_out_en),
        .o_data     (o_data8),
        .o_valid    (o_valid8),
        .o_underflow(o_underflow8)
    );

    task automatic check(input string tag, input logic signed [31:0] observed,
                         input logic signed [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present the head of the feed queue to the DUT.
    task automatic drive();
        i_valid = (feed.size() > 0);
        i_data  = (feed.size() > 0) ? feed[0] : 8'h00;
    endtask

    // One clock: note acceptance before the edge, sample outputs 1 ns after.
    task automatic step();
        logic acc;
        acc = i_valid & o_ready & rst_sync_n;
        @(posedge clk);
        #1;
        if (acc === 1'b1) feed.delete(0);
        if (o_valid === 1'b1) begin
            got.push_back($signed(o_data));
            uf_q.push_back(o_underflow);
        end
        if (o_valid8 === 1'b1) got8.push_back($signed(o_data8));
        drive();
    endtask

    task automatic do_reset();
        rst_sync_n = 1'b0;
        feed.delete();
        drive();
        step();
        step();
        rst_sync_n = 1'b1;
        got.delete();
        got8.delete();
        uf_q.delete();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int cyc = 0;
        while (got.size() < n && cyc < budget) begin
            step();
            cyc++;
        end
        check(tag, (got.size() >= n) ? 1 : 0, 1);
    endtask

    initial begin
        int ones;

        rst_sync_n = 1'b0;
        i_out_en   = 1'b1;
        i_valid    = 1'b0;
        i_data     = 8'h00;
        step();
        step();
        check("rst_o_data",      $signed(o_data), 0);
        check("rst_o_valid",     o_valid,         0);
        check("rst_o_underflow", o_underflow,     0);
        check("rst_o_ready",     o_ready,         0);
        rst_sync_n = 1'b1;
        step();
        check("idle_o_valid", o_valid, 0);
        got.delete();
        got8.delete();
        uf_q.delete();

        // Impulse: 1 then zeros.
        feed.push_back(8'd1);
        repeat (15) feed.push_back(8'd0);
        drive();
        run_until(12, 80, "imp_len");
        for (int i = 0; i < 12; i++)
            check($sformatf("imp[%0d]", i), got[i], exp_imp[i]);
        check("imp_uf", o_underflow, 0);

        // Step of 16, then a freeze with i_out_en low.
        do_reset();
        repeat (20) feed.push_back(8'd16);
        drive();
        run_until(12, 80, "step_len");
        for (int i = 0; i < 8; i++)
            check($sformatf("step[%0d]", i), got[i], exp_step[i]);
        check("step[11]",  got[11],  64);
        check("step8[11]", got8[11], 4);
        check("step_uf",   o_underflow, 0);
        i_out_en = 1'b0;
        repeat (3) step();
        check("frz_valid", o_valid, 0);
        check("frz_data",  $signed(o_data), 64);
        i_out_en = 1'b1;
        got.delete();
        run_until(4, 20, "resume_len");
        check("resume[3]", got[3], 64);

        // Reset mid-run, quiet IDLE, then the step response from scratch.
        rst_sync_n = 1'b0;
        step();
        check("midrst_valid", o_valid, 0);
        check("midrst_data",  $signed(o_data), 0);
        check("midrst_ready", o_ready, 0);
        feed.delete();
        drive();
        rst_sync_n = 1'b1;
        got.delete();
        got8.delete();
        uf_q.delete();
        repeat (6) step();
        check("idle_no_out", got.size(), 0);
        repeat (20) feed.push_back(8'd16);
        drive();
        run_until(8, 60, "restep_len");
        for (int i = 0; i < 8; i++)
            check($sformatf("restep[%0d]", i), got[i], exp_step[i]);

        // Underflow: a single sample of 8.
        do_reset();
        feed.push_back(8'd8);
        drive();
        run_until(12, 80, "uf_len");
        check("uf_before", uf_q[3], 0);
        check("uf_set",    uf_q[4], 1);
        for (int i = 0; i < 12; i++)
            check($sformatf("uf_out[%0d]", i), got[i], exp_uf[i]);
        repeat (20) step();
        check("uf_sticky", o_underflow, 1);
        check("uf_decay",  $signed(o_data), 0);
        do_reset();
        check("uf_cleared", o_underflow, 0);

        // Backpressure: i_valid held with a ramp 1,2,3,...
        for (int v = 1; v <= 40; v++) feed.push_back(8'(v));
        drive();
        run_until(4, 40, "bp_start");
        ones = 0;
        repeat (16) begin
            step();
            if (o_ready === 1'b1) ones++;
        end
        check("bp_ready_ones", ones, 4);
        run_until(24, 120, "bp_len");
        // A gap-free ramp through gain 4 / 4 phases gives y(t) = t - 2.
        for (int t = 3; t < 24; t++)
            check($sformatf("bp_ramp[%0d]", t), got[t], t - 2);
        check("bp_uf", o_underflow, 0);

        // Output width reduction: step of 127.
        do_reset();
        repeat (16) feed.push_back(8'd127);
        drive();
        run_until(12, 80, "trunc_len");
        check("full127[10]",  got[10],  508);
        check("full127[11]",  got[11],  508);
        check("trunc127[10]", got8[10], EXP8_127);
        check("trunc127[11]", got8[11], EXP8_127);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
